// File: rtl/uart_rx_framer.sv
// Frame assembler behind the UART receiver: SYNC, CMD, payload, XOR checksum.
// Validated frames are held on a valid/ready interface; bad or stalled frames raise one-cycle error pulses.
module uart_rx_framer #(
    parameter int         PAYLOAD_BYTES  = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_empty,
    input  logic [7:0]                 rx_data,
    output logic                       uld_rx_data,
    output logic [7:0]                 frame_cmd,
    output logic [8*PAYLOAD_BYTES-1:0] frame_payload,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       err_chksum,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int PAY_W = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t             state_r, state_nxt_s;
    logic               fetch_ph_r;
    logic [7:0]         cmd_r, cmd_nxt_s;
    logic [PAY_W-1:0]   shift_r, shift_nxt_s;
    logic [7:0]         chk_r, chk_nxt_s;
    logic [IDX_W-1:0]   idx_r, idx_nxt_s;
    logic [TMO_W-1:0]   tmo_r, tmo_nxt_s;
    logic [7:0]         frame_cmd_r, frame_cmd_nxt_s;
    logic [PAY_W-1:0]   frame_payload_r, frame_payload_nxt_s;
    logic               frame_valid_r, frame_valid_nxt_s;
    logic               err_chksum_r, err_chksum_nxt_s;
    logic               err_timeout_r, err_timeout_nxt_s;
    logic               busy_r;
    logic               uld_s, strobe_s, framing_s, tmo_hit_s;

    // The byte requested last cycle is on rx_data now; a new unload is never issued in that cycle.
    assign uld_s     = !fetch_ph_r && !rx_empty && (state_r != ST_HOLD);
    assign strobe_s  = fetch_ph_r;
    assign framing_s = (state_r == ST_CMD) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
    assign tmo_hit_s = framing_s && !strobe_s && (tmo_r == TMO_LAST);

    assign uld_rx_data   = uld_s;
    assign frame_cmd     = frame_cmd_r;
    assign frame_payload = frame_payload_r;
    assign frame_valid   = frame_valid_r;
    assign err_chksum    = err_chksum_r;
    assign err_timeout   = err_timeout_r;
    assign busy          = busy_r;

    // Next-state and datapath updates for the frame FSM.
    always_comb begin
        state_nxt_s         = state_r;
        cmd_nxt_s           = cmd_r;
        shift_nxt_s         = shift_r;
        chk_nxt_s           = chk_r;
        idx_nxt_s           = idx_r;
        tmo_nxt_s           = tmo_r;
        frame_cmd_nxt_s     = frame_cmd_r;
        frame_payload_nxt_s = frame_payload_r;
        frame_valid_nxt_s   = frame_valid_r;
        err_chksum_nxt_s    = 1'b0;
        err_timeout_nxt_s   = 1'b0;

        if (tmo_hit_s) begin
            err_timeout_nxt_s = 1'b1;
            state_nxt_s       = ST_HUNT;
            tmo_nxt_s         = '0;
            idx_nxt_s         = '0;
            chk_nxt_s         = 8'h00;
        end else begin
            // A byte strobe always restarts the inter-byte window.
            if (framing_s && !strobe_s) begin
                tmo_nxt_s = tmo_r + TMO_W'(1);
            end else begin
                tmo_nxt_s = '0;
            end

            case (state_r)
                ST_HUNT: begin
                    if (strobe_s && (rx_data == SYNC_BYTE)) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_CMD: begin
                    if (strobe_s) begin
                        cmd_nxt_s   = rx_data;
                        chk_nxt_s   = rx_data;
                        idx_nxt_s   = '0;
                        state_nxt_s = ST_PAYLOAD;
                    end else begin
                        state_nxt_s = ST_CMD;
                    end
                end
                ST_PAYLOAD: begin
                    if (strobe_s) begin
                        shift_nxt_s = PAY_W'({shift_r, rx_data});
                        chk_nxt_s   = chk_update(chk_r, rx_data);
                        if (idx_r == IDX_LAST) begin
                            idx_nxt_s   = '0;
                            state_nxt_s = ST_CHK;
                        end else begin
                            idx_nxt_s   = idx_r + IDX_W'(1);
                            state_nxt_s = ST_PAYLOAD;
                        end
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end
                ST_CHK: begin
                    if (strobe_s && (rx_data == chk_r)) begin
                        frame_cmd_nxt_s     = cmd_r;
                        frame_payload_nxt_s = shift_r;
                        frame_valid_nxt_s   = 1'b1;
                        state_nxt_s         = ST_HOLD;
                    end else if (strobe_s) begin
                        err_chksum_nxt_s = 1'b1;
                        state_nxt_s      = ST_HUNT;
                    end else begin
                        state_nxt_s = ST_CHK;
                    end
                end
                ST_HOLD: begin
                    if (frame_valid_r && frame_ready) begin
                        frame_valid_nxt_s = 1'b0;
                        state_nxt_s       = ST_HUNT;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    frame_valid_nxt_s = 1'b0;
                    state_nxt_s       = ST_HUNT;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, handshake and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_ph_r      <= 1'b0;
            cmd_r           <= 8'h00;
            shift_r         <= '0;
            chk_r           <= 8'h00;
            idx_r           <= '0;
            tmo_r           <= '0;
            frame_cmd_r     <= 8'h00;
            frame_payload_r <= '0;
            frame_valid_r   <= 1'b0;
            err_chksum_r    <= 1'b0;
            err_timeout_r   <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            fetch_ph_r      <= uld_s;
            cmd_r           <= cmd_nxt_s;
            shift_r         <= shift_nxt_s;
            chk_r           <= chk_nxt_s;
            idx_r           <= idx_nxt_s;
            tmo_r           <= tmo_nxt_s;
            frame_cmd_r     <= frame_cmd_nxt_s;
            frame_payload_r <= frame_payload_nxt_s;
            frame_valid_r   <= frame_valid_nxt_s;
            err_chksum_r    <= err_chksum_nxt_s;
            err_timeout_r   <= err_timeout_nxt_s;
            busy_r          <= (state_nxt_s != ST_HUNT);
        end
    end

endmodule
